facto_bus_master: RTL and testbench

Bus initiator that drives the shared m_* bus to run factorial jobs on the FactoCore slave and store results in RAM without software involvement. It accepts a job (operand N, RAM destination address), requests the bus and programs the core. It waits for completion, reads the 128-bit result and writes it to RAM as two 64-bit words. It then clears the core and pulses done. It sits on the master side of the BUS, opposite the RAM and FactoCore slaves.

---
 rtl/facto_bus_master.sv | 186 ++++++++++++++++++
 tb/tb_facto_bus_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/facto_bus_master.sv
// Bus initiator that runs one FactoCore factorial job and stores the 128-bit result in RAM as two 64-bit words.
// Latency: REQ + 3 writes + WAIT + 4 read cycles + 2 writes + opclear + FIN; each grant-low cycle in a bus state adds one.
// Backpressure: cmd_ready is high only in IDLE; bus states hold while m_grant=0 (m_wr forced low, address/data held).
//
// Ports: clk/reset (synchronous, active-high); cmd_valid/cmd_ready/cmd_n/cmd_dst job input;
//        m_req/m_grant/m_wr/m_addr/m_dout/m_din shared bus; interrupt from FactoCore;
//        busy/done/err status; result_h/result_l last captured result (zero after a timeout).
// Build option: define FACTO_POLL_EN to poll opdone instead of waiting on the interrupt pin.
module facto_bus_master #(
    parameter logic [15:0] FC_BASE        = 16'h7000,
    parameter int          TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_n,
    input  logic [15:0] cmd_dst,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [63:0] result_h,
    output logic [63:0] result_l
);

    localparam logic [15:0] OFS_START = 16'h0000;
    localparam logic [15:0] OFS_CLEAR = 16'h0008;
    localparam logic [15:0] OFS_IEN   = 16'h0018;
    localparam logic [15:0] OFS_OPND  = 16'h0020;
    localparam logic [15:0] OFS_RES_H = 16'h0028;
    localparam logic [15:0] OFS_RES_L = 16'h0030;
    localparam logic [12:0] CNT_LAST  = 13'(TIMEOUT_CYCLES - 1);

`ifdef FACTO_POLL_EN
    localparam logic [15:0] OFS_DONE  = 16'h0010;
    localparam logic [63:0] IEN_VAL   = 64'd0;
`else
    localparam logic [63:0] IEN_VAL   = 64'd1;
`endif

    typedef enum logic [3:0] {
        ST_IDLE, ST_REQ, ST_W_IEN, ST_W_OPND, ST_W_START, ST_WAIT, ST_P_RD, ST_P_CAP,
        ST_R_H, ST_C_H, ST_R_L, ST_C_L, ST_W_MH, ST_W_ML, ST_W_CLR, ST_FIN
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] n_q;
    logic [12:0] dst_q;
    logic [12:0] cnt;
    logic        err_q;
    logic [63:0] res_h;
    logic [63:0] res_l;
    logic        wr_state;
    logic        in_wait;
    logic        complete;
    logic        timeout;
    logic        accept;
    logic [15:0] ram_addr_h;
    logic [15:0] ram_addr_l;

    assign accept     = (state == ST_IDLE) && cmd_valid;
    assign ram_addr_h = {dst_q, 3'b000};
    assign ram_addr_l = ram_addr_h + 16'd8;   // 0xFFF8 + 8 wraps to 0x0000

`ifdef FACTO_POLL_EN
    // P_CAP sees the opdone value returned by the read issued in P_RD.
    assign in_wait  = (state == ST_P_RD) || (state == ST_P_CAP);
    assign complete = (state == ST_P_CAP) && m_din[0];
`else
    assign in_wait  = (state == ST_WAIT);
    assign complete = interrupt;
`endif
    // Completion in the same cycle as the last count still wins.
    assign timeout = in_wait && !complete && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cmd_valid) state_nxt = ST_REQ;
            ST_REQ:     if (m_grant)   state_nxt = ST_W_IEN;
            ST_W_IEN:   if (m_grant)   state_nxt = ST_W_OPND;
            ST_W_OPND:  if (m_grant)   state_nxt = ST_W_START;
`ifdef FACTO_POLL_EN
            ST_W_START: if (m_grant)   state_nxt = ST_P_RD;
            ST_P_RD: begin
                if (timeout)      state_nxt = ST_W_CLR;
                else if (m_grant) state_nxt = ST_P_CAP;
            end
            ST_P_CAP: begin
                if (complete)     state_nxt = ST_R_H;
                else if (timeout) state_nxt = ST_W_CLR;
                else              state_nxt = ST_P_RD;
            end
`else
            ST_W_START: if (m_grant)   state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (complete)     state_nxt = ST_R_H;
                else if (timeout) state_nxt = ST_W_CLR;
            end
`endif
            ST_R_H:     if (m_grant)   state_nxt = ST_C_H;
            ST_C_H:                    state_nxt = ST_R_L;
            ST_R_L:     if (m_grant)   state_nxt = ST_C_L;
            ST_C_L:                    state_nxt = ST_W_MH;
            ST_W_MH:    if (m_grant)   state_nxt = ST_W_ML;
            ST_W_ML:    if (m_grant)   state_nxt = ST_W_CLR;
            ST_W_CLR:   if (m_grant)   state_nxt = ST_FIN;
            ST_FIN:                    state_nxt = ST_IDLE;
            default:                   state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs: address/data are a pure function of state, so they stay put while grant is low.
    always_comb begin
        m_req    = 1'b0;
        wr_state = 1'b0;
        m_addr   = 16'd0;
        m_dout   = 64'd0;
        case (state)
            ST_REQ, ST_WAIT, ST_P_CAP, ST_C_H, ST_C_L: m_req = 1'b1;
            ST_W_IEN:   begin m_req = 1'b1; wr_state = 1'b1; m_addr = FC_BASE + OFS_IEN;   m_dout = IEN_VAL; end
            ST_W_OPND:  begin m_req = 1'b1; wr_state = 1'b1; m_addr = FC_BASE + OFS_OPND;  m_dout = n_q;     end
            ST_W_START: begin m_req = 1'b1; wr_state = 1'b1; m_addr = FC_BASE + OFS_START; m_dout = 64'd1;   end
`ifdef FACTO_POLL_EN
            ST_P_RD:    begin m_req = 1'b1; m_addr = FC_BASE + OFS_DONE; end
`endif
            ST_R_H:     begin m_req = 1'b1; m_addr = FC_BASE + OFS_RES_H; end
            ST_R_L:     begin m_req = 1'b1; m_addr = FC_BASE + OFS_RES_L; end
            ST_W_MH:    begin m_req = 1'b1; wr_state = 1'b1; m_addr = ram_addr_h;          m_dout = res_h;   end
            ST_W_ML:    begin m_req = 1'b1; wr_state = 1'b1; m_addr = ram_addr_l;          m_dout = res_l;   end
            ST_W_CLR:   begin m_req = 1'b1; wr_state = 1'b1; m_addr = FC_BASE + OFS_CLEAR; m_dout = 64'd1;   end
            default: ;
        endcase
    end

    assign m_wr      = wr_state & m_grant;
    assign busy      = (state != ST_IDLE);
    assign cmd_ready = (state == ST_IDLE);
    assign done      = (state == ST_FIN);
    assign err       = err_q;
    assign result_h  = res_h;
    assign result_l  = res_l;

    // Job datapath: latched command, wait counter, captured result.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_q   <= 64'd0;
            dst_q <= 13'd0;
            cnt   <= 13'd0;
            err_q <= 1'b0;
            res_h <= 64'd0;
            res_l <= 64'd0;
        end else begin
            // Zero outside the wait states, so it starts from 0 on every wait entry.
            cnt <= in_wait ? cnt + 13'd1 : 13'd0;
            if (accept) begin
                n_q   <= cmd_n;
                dst_q <= cmd_dst[15:3];
                err_q <= 1'b0;
            end
            if (state == ST_C_H) res_h <= m_din;
            if (state == ST_C_L) res_l <= m_din;
            if (timeout) begin
                err_q <= 1'b1;
                res_h <= 64'd0;
                res_l <= 64'd0;
            end
        end
    end

endmodule

// File: tb/tb_facto_bus_master.sv
// Testbench for facto_bus_master: FactoCore + RAM slave model, job-level expectation model, per-cycle compare.
// Latency: not applicable.
// Backpressure: drives m_grant low for a window during one job.
module tb_facto_bus_master;

    localparam int          T  = 64;
    localparam logic [15:0] FC = 16'h7000;
    localparam logic [63:0] MARK = 64'hDEAD_BEEF_0BAD_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_n;
    logic [15:0] cmd_dst;
    logic        m_req;
    logic        m_grant;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] m_din = 64'd0;
    logic        interrupt = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [63:0] result_h;
    logic [63:0] result_l;

    facto_bus_master #(.FC_BASE(FC), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_n(cmd_n), .cmd_dst(cmd_dst), .m_req(m_req), .m_grant(m_grant),
        .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
        .interrupt(interrupt), .busy(busy), .done(done), .err(err),
        .result_h(result_h), .result_l(result_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    // ---------------- job-level model ----------------
    int          cyc = 0;
    bit          active = 0;
    int          acc_edge = 0;
    int          fin_edge = 0;
    int          job_delay = 0;       // completion delay after opstart (cycles, or polls); <0 = never
    int          nxt_delay = 0;
    int          nxt_gap = 0;         // grant-low cycles the stimulus will insert
    logic [63:0] exp_rh, exp_rl;
    bit          exp_err;
    logic [63:0] mdl_rh = 0, mdl_rl = 0;
    bit          mdl_err = 0;
    logic [79:0] wq[$];               // expected bus writes {addr, data}
    logic [127:0] r;
    logic [15:0] dst_al;
    int          pre;

    // ---------------- slave model ----------------
    logic [127:0] fc_res = 0;
    logic [63:0]  opnd = 0;
    bit           fc_done = 0;
    int           cdown = -1;
    int           polls = 0;
    logic [63:0]  ram [0:8191];
    logic         s_req = 0, s_grant = 0, s_wr = 0;
    logic [15:0]  s_addr = 0;
    logic [63:0]  s_dout = 0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            active  = 0;
            wq.delete();
            mdl_rh  = 0;
            mdl_rl  = 0;
            mdl_err = 0;
        end else if (!active && cmd_valid) begin
            active    = 1;
            acc_edge  = cyc;
            job_delay = nxt_delay;
            r         = fact(cmd_n);
            dst_al    = {cmd_dst[15:3], 3'b000};
            pre       = 4 + nxt_gap;      // REQ + three setup writes
            exp_err   = (job_delay < 0);
            if (exp_err) fin_edge = acc_edge + pre + T + 1;
`ifdef FACTO_POLL_EN
            else         fin_edge = acc_edge + pre + 2 * job_delay + 7;
            wq.push_back({FC + 16'h18, 64'd0});
`else
            // WAIT lasts job_delay+1 cycles, then 4 read cycles, 2 RAM writes, opclear.
            else         fin_edge = acc_edge + pre + job_delay + 8;
            wq.push_back({FC + 16'h18, 64'd1});
`endif
            wq.push_back({FC + 16'h20, cmd_n});
            wq.push_back({FC + 16'h00, 64'd1});
            exp_rh = exp_err ? 64'd0 : r[127:64];
            exp_rl = exp_err ? 64'd0 : r[63:0];
            if (!exp_err) begin
                wq.push_back({dst_al, exp_rh});
                wq.push_back({dst_al + 16'd8, exp_rl});
            end
            wq.push_back({FC + 16'h08, 64'd1});
            mdl_err = 0;
        end else if (active && cyc == fin_edge + 1) begin
            active  = 0;
            mdl_rh  = exp_rh;
            mdl_rl  = exp_rl;
            mdl_err = exp_err;
        end

        // Slave side acts on the bus values sampled at the preceding negedge.
        if (s_req && s_grant && s_wr) begin
            if (s_addr == FC + 16'h00) begin
                fc_res = fact(opnd); fc_done = 0; interrupt <= 1'b0; cdown = job_delay; polls = 0;
            end else if (s_addr == FC + 16'h08) begin
                fc_done = 0; interrupt <= 1'b0;
            end else if (s_addr == FC + 16'h20) begin
                opnd = s_dout;
            end else if (s_addr < FC || s_addr > FC + 16'h3F) begin
                ram[s_addr[15:3]] = s_dout;
            end
        end else begin
`ifndef FACTO_POLL_EN
            if (cdown > 0) begin
                cdown--;
                if (cdown == 0) begin fc_done = 1; interrupt <= 1'b1; end
            end
`endif
        end
`ifdef FACTO_POLL_EN
        if (s_req && s_grant && !s_wr && s_addr == FC + 16'h10) begin
            polls++;
            if (cdown > 0 && polls >= cdown) fc_done = 1;
        end
`endif
        if (s_addr == FC + 16'h10)      m_din <= {63'd0, fc_done};
        else if (s_addr == FC + 16'h28) m_din <= fc_res[127:64];
        else if (s_addr == FC + 16'h30) m_din <= fc_res[63:0];
        else if (s_addr >= FC && s_addr <= FC + 16'h3F) m_din <= 64'd0;
        else m_din <= ram[s_addr[15:3]];
    end

    // ---------------- compare process ----------------
    bit done_exp;
    always @(negedge clk) begin
        s_req = m_req; s_grant = m_grant; s_wr = m_wr; s_addr = m_addr; s_dout = m_dout;
        if (cyc > 0) begin
            done_exp = active && (cyc == fin_edge);
            chk("busy", busy, active);
            chk("cmd_ready", cmd_ready, !active);
            chk("done", done, done_exp);
            chk("m_req", m_req, active && !done_exp);
            if (active && cyc == acc_edge) chk("err_clear_on_accept", err, 0);
            if (!active) begin
                chk("idle_m_wr", m_wr, 0);
                chk("idle_m_addr", m_addr, 0);
                chk("idle_m_dout", m_dout, 0);
                chk("idle_err", err, mdl_err);
                chk("idle_result_h", result_h, mdl_rh);
                chk("idle_result_l", result_l, mdl_rl);
            end
            if (m_wr) begin
                chk("write_needs_grant", m_grant, 1);
                chk("write_expected", wq.size() > 0, 1);
                if (wq.size() > 0) begin
                    chk("write_addr", m_addr, wq[0][79:64]);
                    chk("write_data", m_dout, wq[0][63:0]);
                    void'(wq.pop_front());
                end
            end
            if (done_exp) begin
                chk("done_result_h", result_h, exp_rh);
                chk("done_result_l", result_l, exp_rl);
                chk("done_err", err, exp_err);
                chk("writes_outstanding", wq.size(), 0);
`ifdef FACTO_POLL_EN
                if (!exp_err) chk("opdone_reads", polls, job_delay);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept(output int a);
        bit got = 0;
        a = -1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (active && acc_edge == cyc) begin got = 1; a = cyc; end
        end
        chk("accept_seen", got, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 600 && active; i++) begin
            @(posedge clk); #1;
        end
        chk("job_finished", active, 0);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input logic [63:0] n, input logic [15:0] dst, input int delay,
                           input int gap, output int lat);
        int a;
        cmd_n = n; cmd_dst = dst; nxt_delay = delay; nxt_gap = gap; cmd_valid = 1;
        wait_accept(a);
        lat = fin_edge - acc_edge;
        cmd_valid = 0;
        if (gap > 0) begin
            // Accept edge A enters REQ; W_OPND is entered at A+2.
            repeat (2) @(posedge clk);
            #1 m_grant = 0;
            repeat (gap) @(posedge clk);
            #1 m_grant = 1;
        end
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int lat, a1, a2, fin1;
    initial begin
        reset = 1; cmd_valid = 0; cmd_n = 0; cmd_dst = 0; m_grant = 1;
        for (int i = 0; i < 8192; i++) ram[i] = MARK;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);      chk("rst_m_req", m_req, 0);
        chk("rst_m_wr", m_wr, 0);      chk("rst_m_addr", m_addr, 0);
        chk("rst_m_dout", m_dout, 0);  chk("rst_done", done, 0);
        chk("rst_err", err, 0);        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_result_h", result_h, 0); chk("rst_result_l", result_l, 0);
        @(posedge clk); #1 reset = 0;
        repeat (2) @(posedge clk); #1;

        // N=5 -> 120 at 0x10/0x18, interrupt 20 cycles after opstart
        run_job(64'd5, 16'h0010, 20, 0, lat);
`ifdef FACTO_POLL_EN
        chk("j1_latency", lat, 51);
`else
        chk("j1_latency", lat, 32);
`endif
        chk("j1_ram_h", ram[2], 64'd0);
        chk("j1_ram_l", ram[3], 64'd120);
        chk("j1_result_l", result_l, 64'd120);

        // N=0 then N=20 with cmd_valid held; second dst 0xFFFF wraps its low word to 0x0000
        cmd_n = 64'd0; cmd_dst = 16'h0100; nxt_delay = 3; nxt_gap = 0; cmd_valid = 1;
        wait_accept(a1);
        fin1 = fin_edge;
        cmd_n = 64'd20; cmd_dst = 16'hFFFF; nxt_delay = 4;
        wait_accept(a2);
        chk("b2b_second_accept_edge", a2, fin1 + 2);
        cmd_valid = 0;
        wait_idle();
        chk("j2_ram_h", ram[32], 64'd0);
        chk("j2_ram_l", ram[33], 64'd1);
        chk("j3_ram_h", ram[8191], 64'd0);
        chk("j3_ram_l", ram[0], 64'h21C3677C82B40000);
        chk("j3_result_l", result_l, 64'h21C3677C82B40000);

        // N=7 with 10 grant-low cycles in W_OPND
        run_job(64'd7, 16'h0040, 5, 10, lat);
`ifdef FACTO_POLL_EN
        chk("j4_latency", lat, 31);
`else
        chk("j4_latency", lat, 27);
`endif
        chk("j4_ram_l", ram[9], 64'd5040);

        // completion never comes -> timeout
        run_job(64'd9, 16'h0080, -1, 0, lat);
        chk("j5_latency", lat, T + 5);
        chk("j5_err", err, 1);
        chk("j5_result_l", result_l, 64'd0);
        chk("j5_ram_untouched", ram[17], MARK);

        // reset while waiting; the late interrupt then lands in IDLE and must be ignored
        cmd_n = 64'd11; cmd_dst = 16'h00C0; nxt_delay = 12; nxt_gap = 0; cmd_valid = 1;
        wait_accept(a1);
        cmd_valid = 0;
        repeat (8) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        @(negedge clk);
        chk("midjob_rst_busy", busy, 0);
        chk("midjob_rst_m_req", m_req, 0);
        chk("midjob_rst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 reset = 0;
        repeat (20) @(posedge clk); #1;

        run_job(64'd3, 16'h0200, 2, 0, lat);
        chk("j7_ram_l", ram[65], 64'd6);
        chk("j7_result_l", result_l, 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
